// File: rtl/cache_vipt_pkg.sv
// cache_vipt_pkg: shared types and derived-width helpers for the VIPT cache.
//   state_e   - controller states
//   ctag_w    - cache tag width  (ADDR_W-IDX_W-LINE_W-2)
//   vtag_w    - TLB virtual tag width
//   ptag_w    - physical page number width
//   flush_w   - flush counter width, wide enough for the larger of cache/TLB
//   cfg_ok    - index+line+byte bits must fit inside the page offset, so the
//               cache can be indexed with untranslated address bits
package cache_vipt_pkg;

   typedef enum logic [2:0] {
      S_RSTFLUSH, S_IDLE, S_LOOKUP, S_RDREQ, S_REFILL, S_RESP, S_WRREQ, S_FLUSH
   } state_e;

   function automatic int ctag_w(input int addr_w, input int idx_w, input int line_w);
      return addr_w - idx_w - line_w - 2;
   endfunction

   function automatic int vtag_w(input int addr_w, input int page_off_w, input int tlb_idx_w);
      return addr_w - page_off_w - tlb_idx_w;
   endfunction

   function automatic int ptag_w(input int addr_w, input int page_off_w);
      return addr_w - page_off_w;
   endfunction

   function automatic int flush_w(input int idx_w, input int tlb_idx_w);
      return (idx_w > tlb_idx_w) ? idx_w : tlb_idx_w;
   endfunction

   function automatic bit cfg_ok(input int idx_w, input int line_w, input int page_off_w);
      return (idx_w + line_w + 2) <= page_off_w;
   endfunction

endpackage

// File: rtl/cache_vipt_if.sv
// Bus interfaces of the VIPT cache.
//   cache_cpu_if : CPU load/store port (master = CPU, slave = cache)
//     cpu_req/cpu_we/cpu_addr/cpu_wdata -> ; <- cpu_rdata/cpu_ack/mmu_fault
//   cache_mem_if : memory controller port (master = cache, slave = memory)
//     mem_req/mem_we/mem_single/mem_addr/mem_wdata -> ; <- mem_ack/mem_rvalid/mem_rdata
interface cache_cpu_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              mmu_fault;

   modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                   input  cpu_rdata, cpu_ack, mmu_fault);
   modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                   output cpu_rdata, cpu_ack, mmu_fault);
endinterface

interface cache_mem_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              mem_req;
   logic              mem_we;
   logic              mem_single;
   logic [ADDR_W-3:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_req, mem_we, mem_single, mem_addr, mem_wdata,
                   input  mem_ack, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_single, mem_addr, mem_wdata,
                   output mem_ack, mem_rvalid, mem_rdata);
endinterface

// File: rtl/cache_sdp_ram.sv
// cache_sdp_ram: simple dual-port RAM, one write port, registered read.
//   CPU_CLK      clock
//   we/waddr/wdata  write port
//   raddr        read address, rdata valid the cycle after
// Contents are not reset; the cache controller invalidates via valid bits.
module cache_sdp_ram #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          CPU_CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge CPU_CLK) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/cache_vipt.sv
// cache_vipt: direct-mapped VIPT cache with TLB, write-through/no-write-allocate,
// uncached bypass and hardware flush, single clock.
//   CPU_CLK, RST (async, active-low)
//   cpu  : CPU port (cache_cpu_if.slave)
//   mem  : memory controller port (cache_mem_if.master)
//   vmem_act, cache_inhibit : per-access modes, sampled on acceptance
//   flush, tlb_we/tlb_idx/tlb_vtag/tlb_ptag : maintenance, honoured in IDLE only
//   busy : high whenever the controller is not IDLE
module cache_vipt
   import cache_vipt_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int IDX_W      = 8,
   parameter int LINE_W     = 1,
   parameter int PAGE_OFF_W = 12,
   parameter int TLB_IDX_W  = 6
) (
   input  logic                                CPU_CLK,
   input  logic                                RST,
   cache_cpu_if.slave                          cpu,
   cache_mem_if.master                         mem,
   input  logic                                vmem_act,
   input  logic                                cache_inhibit,
   input  logic                                flush,
   input  logic                                tlb_we,
   input  logic [TLB_IDX_W-1:0]                tlb_idx,
   input  logic [ADDR_W-PAGE_OFF_W-TLB_IDX_W-1:0] tlb_vtag,
   input  logic [ADDR_W-PAGE_OFF_W-1:0]        tlb_ptag,
   output logic                                busy
);
   localparam int CTAG_W  = ctag_w(ADDR_W, IDX_W, LINE_W);
   localparam int VTAG_W  = vtag_w(ADDR_W, PAGE_OFF_W, TLB_IDX_W);
   localparam int PTAG_W  = ptag_w(ADDR_W, PAGE_OFF_W);
   localparam int FLUSH_W = flush_w(IDX_W, TLB_IDX_W);
   localparam int DADDR_W = IDX_W + LINE_W;
   localparam int BEAT_W  = (LINE_W > 0) ? LINE_W : 1;
   localparam int TLB_DW  = VTAG_W + PTAG_W + 1;
   localparam logic [BEAT_W-1:0] LMASK = BEAT_W'((1 << LINE_W) - 1);
   localparam logic [ADDR_W-3:0] AMASK = (ADDR_W-2)'(LMASK);

   if (!cfg_ok(IDX_W, LINE_W, PAGE_OFF_W)) begin : g_cfg_err
      $error("cache_vipt: IDX_W+LINE_W+2 must not exceed PAGE_OFF_W");
   end

   state_e              state, nxt;
   logic [ADDR_W-1:2]   va, pa, pa_c, m_addr;
   logic [DATA_W-1:0]   wd, resp, data_rd, d_wd, rdata;
   logic                we_q, vm_q, ci_q;
   logic [BEAT_W-1:0]   beat, woff;
   logic [FLUSH_W-1:0]  fcnt;
   logic [CTAG_W:0]     tag_rd, t_wd;
   logic [TLB_DW-1:0]   tlb_rd, l_wd;
   logic                d_we, t_we, l_we;
   logic [DADDR_W-1:0]  d_wa, line_base;
   logic [IDX_W-1:0]    t_wa;
   logic [TLB_IDX_W-1:0] l_wa;
   logic                accept, beat_fire, fault, hit, last;
   logic                ack, flt, mreq, mwe, msingle;

   cache_sdp_ram #(.AW(DADDR_W), .DW(DATA_W)) u_data (
      .CPU_CLK, .we(d_we), .waddr(d_wa), .wdata(d_wd),
      .raddr(cpu.cpu_addr[DADDR_W+1:2]), .rdata(data_rd));
   cache_sdp_ram #(.AW(IDX_W), .DW(CTAG_W+1)) u_tag (
      .CPU_CLK, .we(t_we), .waddr(t_wa), .wdata(t_wd),
      .raddr(cpu.cpu_addr[DADDR_W+1:LINE_W+2]), .rdata(tag_rd));
   cache_sdp_ram #(.AW(TLB_IDX_W), .DW(TLB_DW)) u_tlb (
      .CPU_CLK, .we(l_we), .waddr(l_wa), .wdata(l_wd),
      .raddr(cpu.cpu_addr[PAGE_OFF_W+TLB_IDX_W-1:PAGE_OFF_W]), .rdata(tlb_rd));

   // Translation and tag compare use RAM outputs read with the index
   // presented in IDLE, so they are valid in LOOKUP.
   always_comb begin
      fault = vm_q && (!tlb_rd[TLB_DW-1] ||
                       tlb_rd[TLB_DW-2:PTAG_W] != va[ADDR_W-1:PAGE_OFF_W+TLB_IDX_W]);
      pa_c  = vm_q ? {tlb_rd[PTAG_W-1:0], va[PAGE_OFF_W-1:2]} : va;
      hit   = tag_rd[CTAG_W] && (tag_rd[CTAG_W-1:0] == pa_c[ADDR_W-1:ADDR_W-CTAG_W]);
      line_base = DADDR_W'(va[DADDR_W+1:LINE_W+2]) << LINE_W;
      woff  = BEAT_W'(va[DADDR_W+1:2]) & LMASK;
      last  = ci_q || (beat == LMASK);
   end

   always_ff @(posedge CPU_CLK or negedge RST) begin
      if (!RST) state <= S_RSTFLUSH;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      ack = 1'b0; flt = 1'b0; rdata = '0;
      mreq = 1'b0; mwe = 1'b0; msingle = 1'b0; m_addr = '0;
      d_we = 1'b0; d_wa = line_base | DADDR_W'(beat); d_wd = mem.mem_rdata;
      t_we = 1'b0; t_wa = va[DADDR_W+1:LINE_W+2]; t_wd = {1'b1, pa[ADDR_W-1:ADDR_W-CTAG_W]};
      l_we = 1'b0; l_wa = tlb_idx; l_wd = {1'b1, tlb_vtag, tlb_ptag};
      accept = 1'b0; beat_fire = 1'b0;
      case (state)
         S_RSTFLUSH, S_FLUSH: begin
            t_we = int'(fcnt) < (1 << IDX_W);
            t_wa = IDX_W'(fcnt);
            t_wd = '0;
            l_we = int'(fcnt) < (1 << TLB_IDX_W);
            l_wa = TLB_IDX_W'(fcnt);
            l_wd = '0;
            if (fcnt == '1) nxt = S_IDLE;
         end
         S_IDLE: begin
            if (flush) nxt = S_FLUSH;
            else if (tlb_we) l_we = 1'b1;
            else if (cpu.cpu_req) begin
               accept = 1'b1;
               nxt    = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (fault) begin
               ack = 1'b1; flt = 1'b1; nxt = S_IDLE;
            end else if (we_q) begin
               nxt = S_WRREQ;
               if (hit && !ci_q) begin
                  d_we = 1'b1; d_wa = va[DADDR_W+1:2]; d_wd = wd;
               end
            end else if (ci_q || !hit) begin
               nxt = S_RDREQ;
            end else begin
               ack = 1'b1; rdata = data_rd; nxt = S_IDLE;
            end
         end
         S_RDREQ: begin
            mreq    = 1'b1;
            msingle = ci_q;
            m_addr  = ci_q ? pa : (pa & ~AMASK);
            if (mem.mem_ack) begin
               nxt = S_REFILL;
               beat_fire = mem.mem_rvalid;  // beat 0 may ride along with the ack
            end
         end
         S_REFILL: beat_fire = mem.mem_rvalid;
         S_RESP: begin
            ack = 1'b1; rdata = resp; nxt = S_IDLE;
         end
         S_WRREQ: begin
            mreq = 1'b1; mwe = 1'b1; msingle = 1'b1; m_addr = pa;
            if (mem.mem_ack) nxt = S_RESP;
         end
         default: nxt = S_IDLE;
      endcase
      if (beat_fire) begin
         d_we = !ci_q;
         if (last) begin
            nxt  = S_RESP;
            t_we = !ci_q;
         end
      end
   end

   always_ff @(posedge CPU_CLK or negedge RST) begin
      if (!RST) begin
         va <= '0; pa <= '0; wd <= '0; resp <= '0;
         we_q <= 1'b0; vm_q <= 1'b0; ci_q <= 1'b0;
         beat <= '0; fcnt <= '0;
      end else begin
         if (accept) begin
            va   <= cpu.cpu_addr[ADDR_W-1:2];
            wd   <= cpu.cpu_wdata;
            we_q <= cpu.cpu_we;
            vm_q <= vmem_act;
            ci_q <= cache_inhibit;
         end
         if (state == S_LOOKUP) begin
            pa   <= pa_c;
            beat <= '0;
         end
         if (beat_fire) begin
            beat <= beat + 1'b1;
            if (ci_q || beat == woff) resp <= mem.mem_rdata;
         end
         if (state == S_WRREQ) resp <= '0;
         if (state == S_FLUSH || state == S_RSTFLUSH) fcnt <= fcnt + 1'b1;
         else                                         fcnt <= '0;
      end
   end

   assign cpu.cpu_ack    = ack;
   assign cpu.mmu_fault  = flt;
   assign cpu.cpu_rdata  = rdata;
   assign mem.mem_req    = mreq;
   assign mem.mem_we     = mwe;
   assign mem.mem_single = msingle;
   assign mem.mem_addr   = m_addr;
   assign mem.mem_wdata  = mwe ? wd : '0;
   assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_cache_vipt.sv
// Directed testbench for cache_vipt: a small word-addressed memory model
// answers the memory port; each step checks hand-computed results.
module tb_cache_vipt;
   logic        CPU_CLK = 1'b0;
   logic        RST = 1'b0;
   logic        vmem_act = 1'b0, cache_inhibit = 1'b0, flush = 1'b0, tlb_we = 1'b0;
   logic [5:0]  tlb_idx = '0;
   logic [13:0] tlb_vtag = '0;
   logic [19:0] tlb_ptag = '0;
   logic        busy;

   cache_cpu_if cif ();
   cache_mem_if mif ();

   cache_vipt dut (
      .CPU_CLK(CPU_CLK), .RST(RST), .cpu(cif), .mem(mif),
      .vmem_act(vmem_act), .cache_inhibit(cache_inhibit), .flush(flush),
      .tlb_we(tlb_we), .tlb_idx(tlb_idx), .tlb_vtag(tlb_vtag), .tlb_ptag(tlb_ptag),
      .busy(busy));

   always #5 CPU_CLK = ~CPU_CLK;

   int tests = 0, fails = 0;
   logic [31:0] mm [logic [29:0]];

   logic [31:0] r_data;
   logic        r_ack, r_fault, r_ms, r_mw;
   logic [29:0] r_ma;
   int          r_ack_cyc, r_req_cyc, r_nreq, r_lastrv;

   task automatic cyc();
      @(posedge CPU_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mrd(input logic [29:0] a);
      return mm.exists(a) ? mm[a] : 32'h0;
   endfunction

   // One CPU access, starting in IDLE at posedge+1. Cycle 1 = LOOKUP.
   // 'same' returns read beat 0 in the same cycle as mem_ack.
   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic vm, input logic ci, input logic same);
      int left;
      logic [29:0] ba;
      left = 0; ba = '0;
      r_ack = 0; r_fault = 0; r_data = '0; r_ms = 0; r_mw = 0; r_ma = '0;
      r_ack_cyc = -1; r_req_cyc = -1; r_nreq = 0; r_lastrv = -1;
      cif.cpu_req = 1; cif.cpu_we = we; cif.cpu_addr = a; cif.cpu_wdata = d;
      vmem_act = vm; cache_inhibit = ci;
      for (int n = 1; n <= 40 && !r_ack; n++) begin
         cyc();
         mif.mem_ack = 0; mif.mem_rvalid = 0;
         if (cif.cpu_ack) begin
            r_ack = 1; r_ack_cyc = n; r_data = cif.cpu_rdata; r_fault = cif.mmu_fault;
         end else if (left > 0) begin
            mif.mem_rvalid = 1; mif.mem_rdata = mrd(ba); ba++; left--;
            if (left == 0) r_lastrv = n;
         end else if (mif.mem_req && r_nreq == 0) begin
            r_nreq = 1; r_req_cyc = n;
            r_ma = mif.mem_addr; r_ms = mif.mem_single; r_mw = mif.mem_we;
            mif.mem_ack = 1;
            if (mif.mem_we) mm[mif.mem_addr] = mif.mem_wdata;
            else begin
               left = mif.mem_single ? 1 : 2; ba = mif.mem_addr;
               if (same) begin
                  mif.mem_rvalid = 1; mif.mem_rdata = mrd(ba); ba++; left--;
                  if (left == 0) r_lastrv = n;
               end
            end
         end
      end
      cif.cpu_req = 0; cif.cpu_we = 0; vmem_act = 0; cache_inhibit = 0;
      mif.mem_ack = 0; mif.mem_rvalid = 0;
      cyc();
   endtask

   initial begin
      int cnt;
      logic ack_seen;
      cif.cpu_req = 0; cif.cpu_we = 0; cif.cpu_addr = '0; cif.cpu_wdata = '0;
      mif.mem_ack = 0; mif.mem_rvalid = 0; mif.mem_rdata = '0;
      mm[30'h40] = 32'hA; mm[30'h41] = 32'hB;
      mm[30'hC02] = 32'h1234; mm[30'hC03] = 32'h5678;

      // Reset state
      cyc(); cyc(); cyc();
      chk("rst_busy", busy, 1);
      chk("rst_ack", cif.cpu_ack, 0);
      chk("rst_mreq", mif.mem_req, 0);
      chk("rst_rdata", cif.cpu_rdata, 0);
      chk("rst_fault", cif.mmu_fault, 0);
      RST = 1;
      cnt = 0;
      while (busy && cnt < 1000) begin cnt++; cyc(); end
      chk("rstflush_len", cnt, 256);

      // Read miss 0x100: line burst at word 0x40
      access(0, 32'h100, 0, 0, 0, 0);
      chk("miss_req_cyc", r_req_cyc, 2);
      chk("miss_maddr", r_ma, 30'h40);
      chk("miss_single", r_ms, 0);
      chk("miss_we", r_mw, 0);
      chk("miss_data", r_data, 32'hA);
      chk("miss_ack_lat", r_ack_cyc, r_lastrv + 1);

      // Read hit 0x104
      access(0, 32'h104, 0, 0, 0, 0);
      chk("hit_lat", r_ack_cyc, 1);
      chk("hit_data", r_data, 32'hB);
      chk("hit_nreq", r_nreq, 0);

      // Store hit 0x100
      access(1, 32'h100, 32'h55, 0, 0, 0);
      chk("st_we", r_mw, 1);
      chk("st_maddr", r_ma, 30'h40);
      chk("st_single", r_ms, 1);
      chk("st_memval", mrd(30'h40), 32'h55);
      chk("st_ack_lat", r_ack_cyc, r_req_cyc + 1);
      access(0, 32'h100, 0, 0, 0, 0);
      chk("st_hit_lat", r_ack_cyc, 1);
      chk("st_hit_data", r_data, 32'h55);

      // TLB entry 1 then translated read on the next cycle
      tlb_we = 1; tlb_idx = 6'd1; tlb_vtag = 14'd0; tlb_ptag = 20'h3;
      cyc();
      tlb_we = 0;
      access(0, 32'h1008, 0, 1, 0, 1);
      chk("vm_req_cyc", r_req_cyc, 2);
      chk("vm_maddr", r_ma, 30'hC02);
      chk("vm_data", r_data, 32'h1234);
      chk("vm_fault", r_fault, 0);
      chk("vm_ack_lat", r_ack_cyc, r_lastrv + 1);

      // Invalid TLB entry -> fault
      access(0, 32'h2008, 0, 1, 0, 0);
      chk("flt_lat", r_ack_cyc, 1);
      chk("flt_fault", r_fault, 1);
      chk("flt_rdata", r_data, 0);
      chk("flt_nreq", r_nreq, 0);

      // Uncached read bypasses the stale line
      mm[30'h40] = 32'h77;
      access(0, 32'h100, 0, 0, 1, 0);
      chk("ci_single", r_ms, 1);
      chk("ci_maddr", r_ma, 30'h40);
      chk("ci_data", r_data, 32'h77);
      access(0, 32'h100, 0, 0, 0, 0);
      chk("ci_after_lat", r_ack_cyc, 1);
      chk("ci_after_data", r_data, 32'h55);

      // Flush and request together: flush wins
      flush = 1; cif.cpu_req = 1; cif.cpu_addr = 32'h100; cif.cpu_we = 0;
      cyc();
      flush = 0;
      chk("fl_busy", busy, 1);
      chk("fl_ack", cif.cpu_ack, 0);
      chk("fl_mreq", mif.mem_req, 0);
      cif.cpu_req = 0;
      cnt = 0;
      while (busy && cnt < 1000) begin cnt++; cyc(); end
      chk("flush_len", cnt, 256);
      access(0, 32'h100, 0, 0, 0, 0);
      chk("fl_miss_req", r_req_cyc, 2);
      chk("fl_miss_data", r_data, 32'h77);

      // Reset during refill beat 0
      cif.cpu_req = 1; cif.cpu_addr = 32'h200; cif.cpu_we = 0;
      cyc();
      cyc();
      chk("rr_mreq_pre", mif.mem_req, 1);
      mif.mem_ack = 1;
      cyc();
      mif.mem_ack = 0; mif.mem_rvalid = 1; mif.mem_rdata = 32'hDEAD;
      RST = 0;
      #1;
      chk("rr_mreq", mif.mem_req, 0);
      chk("rr_maddr", mif.mem_addr, 0);
      chk("rr_ack", cif.cpu_ack, 0);
      chk("rr_busy", busy, 1);
      mif.mem_rvalid = 0; cif.cpu_req = 0;
      cyc();
      RST = 1;
      cnt = 0; ack_seen = 0;
      while (busy && cnt < 1000) begin
         cnt++;
         if (cif.cpu_ack) ack_seen = 1;
         cyc();
      end
      chk("rr_flush_len", cnt, 256);
      chk("rr_no_ack", ack_seen, 0);
      access(0, 32'h104, 0, 0, 0, 0);
      chk("rr_miss_req", r_req_cyc, 2);
      chk("rr_miss_data", r_data, 32'hB);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
